// File: rtl/fft_sample_loader_pkg.sv
// Shared FFT types and helpers: loader FSM states, address bit reversal, Q1.15 product slicing.
// Combinational helpers only; no latency.
// No flow control of its own.
package fft_sample_loader_pkg;

    typedef enum logic [1:0] {FILL, DRAIN, START, BUSY} loader_state_t;

    localparam int SAMPLE_W = 24;

    // Reverse the low n bits of v; bits at and above n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = {<<{v}};
        return r >> (32 - n);
    endfunction

    // Slice a signed w x w product back to Q1.15: p[2w-2 -: w], i.e. floor(p / 2^(w-1)).
    function automatic logic [31:0] q15_slice(input logic signed [63:0] p, input int w);
        logic signed [63:0] t;
        t = p >>> (w - 1);
        return t[31:0];
    endfunction

endpackage

// File: rtl/fft_sample_loader_hann_lut.sv
// Hann window ROM, Q1.15 coefficients tabulated at 32 points and resampled to 2^N_2.
// Latency 1 cycle (registered output).
// No backpressure; a new index may be presented every cycle.
module hann_lut #(
    parameter int width = 16,
    parameter int N_2   = 5
) (
    input  logic             clk,
    input  logic [N_2-1:0]   idx,
    output logic [width-1:0] out
);

    localparam int TAB_LOG2 = 5;

    logic [4:0]  k;
    logic [4:0]  j;
    logic [15:0] c16;

    generate
        if (N_2 <= TAB_LOG2) begin : g_idx_up
            assign k = 5'(idx) << (TAB_LOG2 - N_2);
        end else begin : g_idx_dn
            assign k = idx[N_2-1 -: TAB_LOG2];
        end
    endgenerate

    // The window is symmetric about the midpoint, so only half the table is stored.
    always_comb begin
        j = k[4] ? 5'(6'd32 - {1'b0, k}) : k;
        case (j)
            5'd0:    c16 = 16'd0;
            5'd1:    c16 = 16'd315;
            5'd2:    c16 = 16'd1247;
            5'd3:    c16 = 16'd2761;
            5'd4:    c16 = 16'd4799;
            5'd5:    c16 = 16'd7281;
            5'd6:    c16 = 16'd10114;
            5'd7:    c16 = 16'd13187;
            5'd8:    c16 = 16'd16384;
            5'd9:    c16 = 16'd19580;
            5'd10:   c16 = 16'd22653;
            5'd11:   c16 = 16'd25486;
            5'd12:   c16 = 16'd27968;
            5'd13:   c16 = 16'd30006;
            5'd14:   c16 = 16'd31520;
            5'd15:   c16 = 16'd32452;
            5'd16:   c16 = 16'd32767;
            default: c16 = 16'd0;
        endcase
    end

    generate
        if (width >= 16) begin : g_wide
            always_ff @(posedge clk) out <= width'(c16) << (width - 16);
        end else begin : g_narrow
            always_ff @(posedge clk) out <= c16[15 -: width];
        end
    endgenerate

endmodule

// File: rtl/fft_sample_loader.sv
// Windows one frame of 2^N_2 i2s samples into the FFT RAM, then pulses fft_start and waits for fft_done.
// Write latency 2 cycles from sample_valid, fully pipelined; FFT_LOADER_BITREV_EN selects bit-reversed adr.
// No backpressure: samples arriving outside FILL are dropped and flagged on sticky overrun.
module fft_sample_loader
    import fft_sample_loader_pkg::*;
#(
    parameter int width = 16,
    parameter int N_2   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [SAMPLE_W-1:0]  sample,
    input  logic                 fft_done,
    output logic                 we,
    output logic [N_2-1:0]       adr,
    output logic [2*width-1:0]   wd,
    output logic                 fft_start,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [N_2-1:0] LAST = '1;

    loader_state_t            state;
    logic [N_2-1:0]           count;
    logic                     accept;
    logic [N_2-1:0]           adr_map;
    logic                     s0_vld;
    logic signed [width-1:0]  s0_dat;
    logic [N_2-1:0]           s0_adr;
    logic [width-1:0]         coef;
    logic signed [2*width-1:0] prod;
    logic                     unused_sample_lsbs;

    assign accept             = sample_valid && (state == FILL);
    assign unused_sample_lsbs = ^sample;

`ifdef FFT_LOADER_BITREV_EN
    assign adr_map = N_2'(bitrev(32'(count), N_2));
`else
    assign adr_map = count;
`endif

    hann_lut #(
        .width (width),
        .N_2   (N_2)
    ) u_hann (
        .clk (clk),
        .idx (count),
        .out (coef)
    );

    // Coefficient is non-negative and below 1.0, so its MSB is always 0.
    assign prod = (2*width)'(s0_dat) * (2*width)'($signed(coef));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_vld <= 1'b0;
            s0_dat <= '0;
            s0_adr <= '0;
            we     <= 1'b0;
            adr    <= '0;
            wd     <= '0;
        end else begin
            s0_vld <= accept;
            if (accept) begin
                s0_dat <= sample[SAMPLE_W-1 -: width];
                s0_adr <= adr_map;
            end
            we <= s0_vld;
            if (s0_vld) begin
                adr <= s0_adr;
                wd  <= {width'(q15_slice(64'(prod), width)), {width{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            count     <= '0;
            fft_start <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            fft_start <= 1'b0;
            if (sample_valid && state != FILL)
                overrun <= 1'b1;
            case (state)
                FILL: begin
                    if (sample_valid) begin
                        count <= count + N_2'(1);
                        if (count == LAST) begin
                            state <= DRAIN;
                            busy  <= 1'b1;
                        end
                    end
                end
                // Last write is on the RAM port with nothing left behind it in stage 0.
                DRAIN: begin
                    if (we && !s0_vld) begin
                        state     <= START;
                        fft_start <= 1'b1;
                    end
                end
                START: state <= BUSY;
                BUSY: begin
                    if (fft_done) begin
                        state <= FILL;
                        busy  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: a Hann/arithmetic reference model queues expected RAM writes,
// a negedge monitor pops and compares them and checks fft_start placement.
module tb_fft_sample_loader;

    localparam int W  = 16;
    localparam int N2 = 5;
    localparam int N  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            sample_valid = 1'b0;
    logic [23:0]     sample = '0;
    logic            fft_done = 1'b0;
    logic            we;
    logic [N2-1:0]   adr;
    logic [2*W-1:0]  wd;
    logic            fft_start;
    logic            busy;
    logic            overrun;

    fft_sample_loader #(.width(W), .N_2(N2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .fft_done     (fft_done),
        .we           (we),
        .adr          (adr),
        .wd           (wd),
        .fft_start    (fft_start),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N2-1:0]  adr;
        logic [2*W-1:0] wd;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    wr_t         exp_q[$];
    int          wr_cyc_q[$];
    int          fill_cnt = 0;
    bit          frame_full = 0;
    int          wr_cnt = 0;
    bit          prev_last = 0;
    bit          start_seen = 0;
    logic [23:0] frm[N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hann(int k);
        real r;
        r = 32767.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * k / N));
        return $rtoi(r + 0.5 + 1.0e-6);
    endfunction

    function automatic logic [N2-1:0] exp_adr(int k);
        logic [N2-1:0] a;
`ifdef FFT_LOADER_BITREV_EN
        a = '0;
        for (int b = 0; b < N2; b++)
            if (((k >> b) & 1) == 1) a = a | N2'(1 << (N2 - 1 - b));
`else
        a = N2'(k);
`endif
        return a;
    endfunction

    function automatic logic [2*W-1:0] exp_wd(int k, logic [23:0] smp);
        longint s;
        longint p;
        s = longint'($signed(smp[23:8]));
        p = s * hann(k);
        return {16'(p >>> 15), 16'h0000};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_sample(logic [23:0] smp);
        if (!frame_full) begin
            exp_q.push_back('{adr: exp_adr(fill_cnt), wd: exp_wd(fill_cnt, smp)});
            fill_cnt++;
            if (fill_cnt == N) frame_full = 1;
        end
    endtask

    task automatic drive(bit v, logic [23:0] smp);
        sample_valid = v;
        sample = smp;
        if (v) model_sample(smp);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(int gmin, int gmax);
        for (int k = 0; k < N; k++) begin
            drive(1'b1, frm[k]);
            idle($urandom_range(gmax, gmin));
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!start_seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("fft_start_seen", 64'(start_seen), 64'd1);
        start_seen = 0;
    endtask

    task automatic pulse_done(bit in_busy);
        fft_done = 1'b1;
        if (in_busy) begin
            fill_cnt = 0;
            frame_full = 0;
        end
        @(posedge clk);
        #1;
        fft_done = 1'b0;
    endtask

    task automatic finish_frame();
        wait_start();
        check("busy_before_done", 64'(busy), 64'd1);
        pulse_done(1'b1);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic random_frame();
        for (int k = 0; k < N; k++) frm[k] = 24'($urandom);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            wr_cnt = 0;
            prev_last = 0;
        end else begin
            if (fft_start || prev_last) check("fft_start_after_last_write", 64'(fft_start), 64'(prev_last));
            if (fft_start) start_seen = 1;
            if (prev_last) wr_cnt = 0;
            prev_last = 0;
            if (we) begin
                wr_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_adr", 64'(adr), 64'(e.adr));
                    check("write_wd", 64'(wd), 64'(e.wd));
                end
                wr_cnt++;
                prev_last = (wr_cnt == N);
            end
        end
    end

    initial begin
        int t0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 64'(we), 64'd0);
        check("rst_adr", 64'(adr), 64'd0);
        check("rst_wd", 64'(wd), 64'd0);
        check("rst_fft_start", 64'(fft_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b1;
        idle(3);
        check("post_rst_we", 64'(we), 64'd0);
        check("post_rst_fft_start", 64'(fft_start), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_overrun", 64'(overrun), 64'd0);

        // Constant full-scale-ish input, one sample every 8 cycles.
        for (int k = 0; k < N; k++) frm[k] = 24'h7FFF00;
        send_frame(7, 7);
        finish_frame();
        check("overrun_after_slow_frame", 64'(overrun), 64'd0);

        // fft_done outside BUSY must be ignored.
        idle(2);
        pulse_done(1'b0);
        check("busy_done_in_fill", 64'(busy), 64'd0);

        // Back-to-back burst: 32 consecutive writes, first one 2 cycles after the first valid.
        random_frame();
        wr_cyc_q.delete();
        t0 = cyc;
        send_frame(0, 0);
        finish_frame();
        if (wr_cyc_q.size() >= N) begin
            check("burst_first_write_latency", 64'(wr_cyc_q[0] - t0), 64'd2);
            check("burst_write_span", 64'(wr_cyc_q[N-1] - wr_cyc_q[0]), 64'(N - 1));
        end else begin
            check("burst_write_count", 64'(wr_cyc_q.size()), 64'(N));
        end
        check("overrun_after_burst", 64'(overrun), 64'd0);

        // Most negative sample against the peak coefficient.
        random_frame();
        frm[16] = 24'h800000;
        send_frame(0, 3);
        finish_frame();

        // Tiny positive sample against the peak coefficient, then a drop while BUSY.
        random_frame();
        frm[16] = 24'h000100;
        send_frame(0, 3);
        wait_start();
        drive(1'b1, 24'h123456);
        check("overrun_busy_drop", 64'(overrun), 64'd1);
        check("busy_during_drop", 64'(busy), 64'd1);
        idle(2);
        pulse_done(1'b1);
        check("busy_fall_after_done", 64'(busy), 64'd0);

        // Restart immediately after fft_done, then abort the frame with reset after 10 samples.
        random_frame();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, frm[k]);
            idle($urandom_range(2, 0));
        end
        idle(4);
        check("partial_frame_writes_done", 64'(exp_q.size()), 64'd0);
        check("overrun_still_set", 64'(overrun), 64'd1);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        exp_q.delete();
        fill_cnt = 0;
        frame_full = 0;
        idle(4);
        check("overrun_cleared_by_reset", 64'(overrun), 64'd0);
        check("busy_after_abort", 64'(busy), 64'd0);
        check("no_start_after_abort", 64'(start_seen), 64'd0);

        random_frame();
        send_frame(0, 2);
        finish_frame();

        idle(5);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Upstream stage of the FFT core. It takes audio samples from the `i2s` receiver and multiplies each one by the matching Hann coefficient. It writes the windowed frame of N = 2^N_2 points into the FFT's two-port RAM in bit-reversed order, then hands off to the AGU with a one-cycle `fft_start` pulse. It waits for `fft_done` before loading the next frame (no overlap).

## Interface
Parameters:
- `width`, 16, sample/coefficient bits (signed Q1.15); RAM word is 2*`width`.
- `N_2`, 5, log2 of FFT length N.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe from `i2s`; `sample` is valid in that cycle.
- `sample`  in  24  signed audio word (left channel).
- `fft_done`  in  1  FFT core finished the current frame.
- `we`  out  1  RAM write enable.
- `adr`  out  N_2  RAM write address.
- `wd`  out  2*width  RAM write data {re, im}; im is always 0.
- `fft_start`  out  1  one-cycle pulse: frame loaded.
- `busy`  out  1  high outside FILL.
- `overrun`  out  1  sticky; a sample was dropped. Cleared only by reset.

## Operation
- FSM states: FILL, DRAIN, START, BUSY. Reset state is FILL, with count=0.
- FILL: each `sample_valid` accepts one sample at index `count`, then `count++`. When sample N-1 is accepted, go to DRAIN.
- DRAIN: wait until the last pipelined write has issued, then go to START.
- START: `fft_start`=1 for exactly one cycle, then go to BUSY.
- BUSY: on `fft_done`=1, go to FILL with count=0.
- `fft_done` is sampled only in BUSY; it is ignored in all other states.
- `sample_valid` in DRAIN, START or BUSY: sample dropped, `overrun`←1.
- Arithmetic:
  - s = `sample`[23 -: width].
  - h = Hann coefficient for index `count`, read from the LUT (non-negative, ≤ 0x7FFF).
  - p = s*h, signed, 2*width bits.
  - re = p[2*width-2 -: width]; this truncates toward −∞ and never saturates because |h| < 1.
- `wd` = {re, width'b0}.
- `adr` = bit-reverse(count) on N_2 bits.
- Reset mid-frame (any state) aborts the frame. No further writes or start pulse occur; the next frame starts at index 0.

## Timing
- Reset values: `we`=0, `adr`=0, `wd`=0, `fft_start`=0, `busy`=0, `overrun`=0.
- Pipeline, with valid at cycle T:
  - T: s captured and LUT index driven.
  - T+1: LUT data valid, product registered.
  - T+2: `we`=1 with `adr`/`wd`.
- Write latency is 2 cycles, fully pipelined; `sample_valid` may be high every cycle.
- Last write in cycle W: DRAIN covers cycle W, `fft_start` is high in W+1, and `busy` is high from the cycle after the last acceptance until the cycle after `fft_done`.
- The first sample accepted in FILL after BUSY can arrive the cycle after `fft_done`.

## Configuration
- `FFT_LOADER_BITREV_EN` defined: `adr` = bit-reverse(count), for the in-place decimation-in-time AGU.
- Not defined: `adr` = count (natural order); this requires an AGU that reorders itself.
- Everything else is identical in both builds.

## Structure
- The shared FFT package holds:
  - the `loader_state_t` enum {FILL, DRAIN, START, BUSY};
  - a `bitrev` function parameterised on N_2;
  - the Q1.15 product-slice helper, also used by `fft_butterfly`.
- One sub-module: `hann_lut` (synchronous ROM, `clk`, `idx`, `out`, 1-cycle latency), instantiated internally and addressed by `count`.

## Test plan
(N_2=5, N=32)
- Reset asserted low for 3 cycles, then released → all outputs 0, no `we`, no `fft_start`.
- 32 samples of 24'h7FFF00, one every 8 cycles, BITREV_EN defined → 32 writes with `adr` 0,16,8,24,4,…,31.
  - `wd`[31:16] = (0x7FFF*h[k])>>>15 and `wd`[15:0]=0.
  - `fft_start` is high exactly one cycle, immediately after the 32nd write.
- 32 back-to-back `sample_valid` cycles → `we` high for 32 consecutive cycles, starting 2 cycles after the first valid; `overrun`=0.
- With h=0x7FFF, `sample`=24'h800000 → `wd`=32'h8001_0000; `sample`=24'h000100 → `wd`[31:16]=0x0000 (truncation toward −∞ check: 1*0x7FFF>>>15 = 0).
- Sample during BUSY → no `we`, `overrun`=1.
  - Then `fft_done` → `busy` falls; the next sample writes at `adr` 0 with `overrun` still 1.
- Reset pulse after 10 accepted samples → no `fft_start`.
  - The following 32 samples produce a full frame starting at `adr` 0; without BITREV_EN, `adr` runs 0..31 in order.
